player_ctrl: RTL and testbench

Sequencer for the player ship sprite. It owns the ship's top-left screen position, life count and alive/exploding/respawn/game-over state. It moves the ship on frame ticks from button levels and reacts to collision pulses from the hit-detection logic. Its position outputs drive the ship's rectangle/bitmap pair, and its visibility output gates the bitmap's draw request.

---
 rtl/player_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_player_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// player_ctrl
//   Sequencer for the player ship sprite: owns the ship's top-left position,
//   the life count and the ALIVE / EXPLODE / RESPAWN / GAME_OVER state.
//   The ship moves on frame ticks from button levels, and the block reacts to
//   collision pulses from the hit-detection logic. All outputs are registered.
//
// Ports
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  one-cycle pulse per video frame
//   moveLeft      left button level (sampled only on startOfFrame)
//   moveRight     right button level (sampled only on startOfFrame)
//   collision     one-cycle pulse: enemy missile/alien overlapped ship pixels
//   newGame       one-cycle pulse: restart from any state
//   topLeftX      ship X position
//   topLeftY      ship Y position (constant Y_POS)
//   playerVisible gates the bitmap draw request (blinks during RESPAWN)
//   exploding     high in EXPLODE (selects explosion art)
//   fireEnable    player may launch a shot (ALIVE only)
//   lives         remaining lives
//   gameOver      high in GAME_OVER
module player_ctrl #(
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 607,
  parameter int START_X        = 304,
  parameter int Y_POS          = 440,
  parameter int SPEED          = 4,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 32,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        moveLeft,
  input  logic        moveRight,
  input  logic        collision,
  input  logic        newGame,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        playerVisible,
  output logic        exploding,
  output logic        fireEnable,
  output logic [2:0]  lives,
  output logic        gameOver
);

  localparam logic [1:0] ST_ALIVE     = 2'd0;
  localparam logic [1:0] ST_EXPLODE   = 2'd1;
  localparam logic [1:0] ST_RESPAWN   = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  logic [1:0]  state_q,   state_nxt;
  logic [6:0]  frame_q,   frame_nxt;
  logic [10:0] x_q,       x_nxt;
  logic [2:0]  lives_q,   lives_nxt;
  logic        visible_q, visible_nxt;
  logic        explode_q, fire_q, over_q;

  logic [10:0] x_moved;
  logic [11:0] x_wide;
  logic [11:0] x_inc;

  // Candidate position after one frame of movement. The left clamp is
  // decided before subtracting, so the subtraction can never wrap; the
  // right side is summed in 12 bits so the overflow is visible to the clamp.
  always_comb begin
    x_wide  = {1'b0, x_q};
    x_inc   = x_wide + 12'(SPEED);
    x_moved = x_q;
    if (moveLeft && !moveRight) begin
      if (x_wide < 12'(X_MIN + SPEED))
        x_moved = 11'(X_MIN);
      else
        x_moved = x_q - 11'(SPEED);
    end else if (moveRight && !moveLeft) begin
      if (x_inc > 12'(X_MAX))
        x_moved = 11'(X_MAX);
      else
        x_moved = x_inc[10:0];
    end
  end

  // Next-state logic. newGame has top priority; within ALIVE a collision
  // beats the frame move; in RESPAWN collisions are never looked at, so a
  // terminal frame coinciding with a collision simply returns to ALIVE.
  always_comb begin
    state_nxt = state_q;
    frame_nxt = frame_q;
    x_nxt     = x_q;
    lives_nxt = lives_q;

    if (newGame) begin
      state_nxt = ST_ALIVE;
      frame_nxt = '0;
      x_nxt     = 11'(START_X);
      lives_nxt = 3'(LIVES);
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (collision) begin
            lives_nxt = lives_q - 3'd1;
            frame_nxt = '0;
            state_nxt = (lives_q == 3'd1) ? ST_GAME_OVER : ST_EXPLODE;
          end else if (startOfFrame) begin
            x_nxt     = x_moved;
            frame_nxt = frame_q + 7'd1;
          end
        end
        ST_EXPLODE: begin
          if (startOfFrame) begin
            if (frame_q == 7'(EXPLODE_FRAMES - 1)) begin
              state_nxt = ST_RESPAWN;
              frame_nxt = '0;
              x_nxt     = 11'(START_X);
            end else begin
              frame_nxt = frame_q + 7'd1;
            end
          end
        end
        ST_RESPAWN: begin
          if (startOfFrame) begin
            x_nxt = x_moved;
            if (frame_q == 7'(BLINK_FRAMES - 1)) begin
              state_nxt = ST_ALIVE;
              frame_nxt = '0;
            end else begin
              frame_nxt = frame_q + 7'd1;
            end
          end
        end
        default: begin
          if (startOfFrame)
            frame_nxt = frame_q + 7'd1;
        end
      endcase
    end
  end

  // Visibility is derived from the next state/count so the registered
  // output lines up with the registered state.
  always_comb begin
    visible_nxt = 1'b0;
    if (state_nxt == ST_ALIVE)
      visible_nxt = 1'b1;
    else if (state_nxt == ST_RESPAWN)
      visible_nxt = ~frame_nxt[2];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_ALIVE;
      frame_q   <= '0;
      x_q       <= 11'(START_X);
      lives_q   <= 3'(LIVES);
      visible_q <= 1'b1;
      explode_q <= 1'b0;
      fire_q    <= 1'b1;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      frame_q   <= frame_nxt;
      x_q       <= x_nxt;
      lives_q   <= lives_nxt;
      visible_q <= visible_nxt;
      explode_q <= (state_nxt == ST_EXPLODE);
      fire_q    <= (state_nxt == ST_ALIVE);
      over_q    <= (state_nxt == ST_GAME_OVER);
    end
  end

  assign topLeftX      = x_q;
  assign topLeftY      = 11'(Y_POS);
  assign playerVisible = visible_q;
  assign exploding     = explode_q;
  assign fireEnable    = fire_q;
  assign lives         = lives_q;
  assign gameOver      = over_q;

endmodule

// File: tb/tb_player_ctrl.sv
module tb_player_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        moveLeft = 1'b0;
  logic        moveRight = 1'b0;
  logic        collision = 1'b0;
  logic        newGame = 1'b0;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        playerVisible;
  logic        exploding;
  logic        fireEnable;
  logic [2:0]  lives;
  logic        gameOver;

  player_ctrl #(
    .X_MIN(0), .X_MAX(607), .START_X(304), .Y_POS(440), .SPEED(4),
    .LIVES(3), .EXPLODE_FRAMES(32), .BLINK_FRAMES(64)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .moveLeft(moveLeft), .moveRight(moveRight), .collision(collision),
    .newGame(newGame), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .playerVisible(playerVisible), .exploding(exploding),
    .fireEnable(fireEnable), .lives(lives), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: game mode, position, lives, frames seen since entering
  // the current mode.
  localparam int M_ALIVE = 0, M_EXPL = 1, M_RESP = 2, M_OVER = 3;
  int m_mode, m_x, m_lives, m_frames;

  function automatic void model_reset();
    m_mode = M_ALIVE; m_x = 304; m_lives = 3; m_frames = 0;
  endfunction

  function automatic int move(int x, bit l, bit r);
    if (l && !r) return (x - 4 < 0) ? 0 : x - 4;
    if (r && !l) return (x + 4 > 607) ? 607 : x + 4;
    return x;
  endfunction

  function automatic void model_step(bit s, bit l, bit r, bit c, bit n);
    if (n) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_ALIVE:
        if (c) begin
          m_lives  = m_lives - 1;
          m_mode   = (m_lives == 0) ? M_OVER : M_EXPL;
          m_frames = 0;
        end else if (s) begin
          m_x = move(m_x, l, r);
        end
      M_EXPL:
        if (s) begin
          m_frames++;
          if (m_frames == 32) begin
            m_mode = M_RESP; m_frames = 0; m_x = 304;
          end
        end
      M_RESP:
        if (s) begin
          m_x = move(m_x, l, r);
          m_frames++;
          if (m_frames == 64) begin
            m_mode = M_ALIVE; m_frames = 0;
          end
        end
      default: ;
    endcase
  endfunction

  function automatic bit model_visible();
    if (m_mode == M_ALIVE) return 1'b1;
    if (m_mode == M_RESP) return (m_frames % 8) < 4;
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("topLeftX", 16'(topLeftX), 16'(m_x));
    chk("topLeftY", 16'(topLeftY), 16'd440);
    chk("playerVisible", 16'(playerVisible), 16'(model_visible()));
    chk("exploding", 16'(exploding), 16'(m_mode == M_EXPL));
    chk("fireEnable", 16'(fireEnable), 16'(m_mode == M_ALIVE));
    chk("lives", 16'(lives), 16'(m_lives));
    chk("gameOver", 16'(gameOver), 16'(m_mode == M_OVER));
  endtask

  task automatic cyc(bit s, bit l, bit r, bit c, bit n);
    startOfFrame = s; moveLeft = l; moveRight = r; collision = c; newGame = n;
    @(posedge clk);
    model_step(s, l, r, c, n);
    #1;
    check_all();
    startOfFrame = 1'b0; collision = 1'b0; newGame = 1'b0;
  endtask

  // One frame pulse followed by an idle cycle with the buttons still held.
  task automatic frame(bit l, bit r);
    cyc(1'b1, l, r, 1'b0, 1'b0);
    cyc(1'b0, l, r, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    chk("reset_x", 16'(topLeftX), 16'd304);
    #3 resetN = 1'b1;

    // Right to the wall, then both buttons.
    for (int i = 0; i < 80; i++) frame(1'b0, 1'b1);
    chk("right_cap", 16'(topLeftX), 16'd607);
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b1);
    chk("both_held", 16'(topLeftX), 16'd607);

    // Left to the wall; 607 - 4*151 = 3, next step clamps to 0.
    for (int i = 0; i < 151; i++) frame(1'b1, 1'b0);
    chk("near_left", 16'(topLeftX), 16'd3);
    frame(1'b1, 1'b0);
    chk("left_clamp", 16'(topLeftX), 16'd0);
    frame(1'b1, 1'b0);
    chk("left_stay", 16'(topLeftX), 16'd0);

    // Collision at X = 100, explode, respawn blink, back to ALIVE.
    for (int i = 0; i < 25; i++) frame(1'b0, 1'b1);
    chk("at_100", 16'(topLeftX), 16'd100);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hit_lives", 16'(lives), 16'd2);
    chk("hit_explode", 16'(exploding), 16'd1);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame(1'b0, 1'b0);
    end
    chk("respawn_x", 16'(topLeftX), 16'd304);
    for (int i = 0; i < 64; i++) begin
      chk("blink", 16'(playerVisible), 16'((i % 8) < 4));
      if (i == 10) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frame(1'b0, 1'b0);
    end
    chk("alive_again", 16'(fireEnable), 16'd1);
    chk("lives_kept", 16'(lives), 16'd2);

    // Collision with frame pulse and moveRight: move dropped.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("col_sof_x", 16'(topLeftX), 16'd304);
    chk("col_sof_lives", 16'(lives), 16'd1);
    for (int i = 0; i < 96; i++) frame(1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("game_over", 16'(gameOver), 16'd1);
    chk("go_lives", 16'(lives), 16'd0);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b1);
    chk("go_frozen", 16'(topLeftX), 16'd304);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("newgame_lives", 16'(lives), 16'd3);

    // Terminal RESPAWN frame coincident with collision.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) frame(1'b0, 1'b0);
    for (int i = 0; i < 63; i++) frame(1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("term_alive", 16'(fireEnable), 16'd1);
    chk("term_lives", 16'(lives), 16'd2);

    // Async reset in mid-RESPAWN.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) frame(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) frame(1'b0, 1'b1);
    resetN = 1'b0;
    #1;
    model_reset();
    check_all();
    #10 resetN = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ng_col_lives", 16'(lives), 16'd3);
    chk("ng_col_fire", 16'(fireEnable), 16'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 399) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
